// File: rtl/sm_result_buffer_if.sv
// Result-beat bus between the SM core, the buffer and its consumer.
// slave = buffer view; master = producer/consumer (testbench) view.
interface sm_result_buffer_if;
  logic        d_valid;
  logic [19:0] out_data;
  logic [2:0]  err_code;
  logic [9:0]  pc;
  logic        fin;
  logic        o_valid;
  logic        o_ready;
  logic [19:0] o_data;
  logic [2:0]  o_err;
  logic [9:0]  o_pc;

  modport slave (
    input  d_valid, out_data, err_code, pc, fin, o_ready,
    output o_valid, o_data, o_err, o_pc
  );

  modport master (
    output d_valid, out_data, err_code, pc, fin, o_ready,
    input  o_valid, o_data, o_err, o_pc
  );
endinterface

// File: rtl/sm_result_buffer.sv
// SM result FIFO: one-cycle write latency, valid/ready drain, RUN->DRAIN->DONE after fin.
// Full without pop drops the beat (sticky overflow); SM_RESULT_ERRCNT_EN enables err_cnt.
module sm_result_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  sm_result_buffer_if.slave bus,
  output logic [AW:0]       count,
  output logic              full,
  output logic              overflow,
  output logic [9:0]        res_cnt,
  output logic [9:0]        err_cnt,
  output logic              done
);

  typedef struct packed {
    logic [19:0] data;
    logic [2:0]  err;
    logic [9:0]  pc;
  } beat_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  beat_t         mem [DEPTH];
  beat_t         head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  state_t        state, state_nxt;
  logic          empty, push, pop, accept;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign done   = (state == ST_DONE);
  assign push   = bus.d_valid & (state == ST_RUN);
  assign pop    = bus.o_valid & bus.o_ready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign accept = push & (~full | pop);

  assign bus.o_valid = ~empty & (state != ST_DONE);
  assign head        = empty ? '0 : mem[rd_ptr];
  assign bus.o_data  = head.data;
  assign bus.o_err   = head.err;
  assign bus.o_pc    = head.pc;

  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (bus.fin) state_nxt = ST_DRAIN;
      ST_DRAIN: if (count_nxt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= '{data: bus.out_data, err: bus.err_code, pc: bus.pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      res_cnt  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      if (push & full & ~pop) overflow <= 1'b1;
      if (accept && res_cnt != 10'd1023) res_cnt <= res_cnt + 10'd1;
    end
  end

`ifdef SM_RESULT_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && bus.err_code != 3'd0 && err_cnt != 10'd1023) begin
      err_cnt <= err_cnt + 10'd1;
    end
  end
`else
  assign err_cnt = 10'd0;
`endif

endmodule

// File: tb/tb_sm_result_buffer.sv
// Randomized and directed bench for sm_result_buffer against a queue-based reference model.
module tb_sm_result_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk;
  logic        rst_n;
  logic [AW:0] count;
  logic        full, overflow, done;
  logic [9:0]  res_cnt, err_cnt;

  sm_result_buffer_if sif();

  sm_result_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (sif),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .res_cnt  (res_cnt),
    .err_cnt  (err_cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: queue of {data, err, pc}; fin_seen marks any earlier cycle with fin.
  logic [32:0] mq[$];
  bit          m_ovf, m_fin, m_done;
  int          m_res, m_errc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 0;
    m_fin  = 0;
    m_done = 0;
    m_res  = 0;
    m_errc = 0;
  endtask

  task automatic check_outputs();
    logic [32:0] h;
    bit          ov;
    int          exp_err;
    ov = (mq.size() != 0) && !m_done;
    h  = ov ? mq[0] : 33'd0;
`ifdef SM_RESULT_ERRCNT_EN
    exp_err = m_errc;
`else
    exp_err = 0;
`endif
    chk("count",    32'(count),      32'(mq.size()));
    chk("full",     32'(full),       32'(mq.size() == DEPTH));
    chk("o_valid",  32'(sif.o_valid), 32'(ov));
    chk("overflow", 32'(overflow),   32'(m_ovf));
    chk("res_cnt",  32'(res_cnt),    32'(m_res));
    chk("err_cnt",  32'(err_cnt),    32'(exp_err));
    chk("done",     32'(done),       32'(m_done));
    chk("o_data",   32'(sif.o_data), 32'(h[32:13]));
    chk("o_err",    32'(sif.o_err),  32'(h[12:10]));
    chk("o_pc",     32'(sif.o_pc),   32'(h[9:0]));
  endtask

  // Entered at a negedge: check, drive, advance one clock, update model, return at negedge.
  task automatic cyc(input bit dv, input logic [19:0] d, input logic [2:0] e,
                     input logic [9:0] p, input bit f, input bit r);
    bit ov;
    check_outputs();
    sif.d_valid  = dv;
    sif.out_data = d;
    sif.err_code = e;
    sif.pc       = p;
    sif.fin      = f;
    sif.o_ready  = r;
    @(posedge clk);
    ov = (mq.size() != 0) && !m_done;
    if (ov && r) void'(mq.pop_front());
    if (dv && !m_fin) begin
      if (mq.size() < DEPTH) begin
        mq.push_back({d, e, p});
        if (m_res < 1023) m_res++;
        if (e != 3'd0 && m_errc < 1023) m_errc++;
      end else begin
        m_ovf = 1;
      end
    end
    if (m_fin && mq.size() == 0) m_done = 1;
    if (f) m_fin = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 20'd0, 3'd0, 10'd0, 0, r);
  endtask

  task automatic do_reset();
    sif.d_valid  = 0;
    sif.out_data = '0;
    sif.err_code = '0;
    sif.pc       = '0;
    sif.fin      = 0;
    sif.o_ready  = 0;
    rst_n        = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [19:0] rd;
    logic [2:0]  re;
    logic [9:0]  rp;
    int          pdv, prdy, fin_at;
    n_vec = 0;
    n_err = 0;
    rst_n = 0;
    @(negedge clk);
    do_reset();

    // T1: asynchronous reset with entries held
    for (int i = 0; i < 3; i++) cyc(1, 20'(i + 1), 3'd1, 10'(i), 0, 0);
    check_outputs();
    #2 rst_n = 0;
    #1;
    chk("t1_count",    32'(count),       32'd0);
    chk("t1_o_valid",  32'(sif.o_valid), 32'd0);
    chk("t1_overflow", 32'(overflow),    32'd0);
    chk("t1_res_cnt",  32'(res_cnt),     32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // T2: ordering of signed results
    cyc(1, 20'd5,     3'd1, 10'd100, 0, 0);
    cyc(1, 20'hFFFFD, 3'd0, 10'd101, 0, 0);
    cyc(1, 20'hFFFFF, 3'd3, 10'd102, 0, 0);
    idle(2, 0);
    idle(4, 1);

    // T3: overflow on the ninth beat
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 20'(i * 7 + 1), 3'd0, 10'(i + 1), 0, 0);
    idle(1, 0);
    idle(9, 1);

    // T4: push and pop together while full
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 20'(i + 40), 3'd0, 10'(i + 1), 0, 0);
    cyc(1, 20'd99, 3'd2, 10'd9, 0, 1);
    idle(10, 1);

    // T5: fin with a same-cycle beat, then ignored beats, then drain to done
    do_reset();
    cyc(1, 20'd11, 3'd0, 10'd1, 0, 0);
    cyc(1, 20'd12, 3'd0, 10'd2, 0, 0);
    cyc(1, 20'd13, 3'd4, 10'd3, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 20'(i + 70), 3'd1, 10'(i + 70), 0, 0);
    idle(6, 1);
    cyc(1, 20'd5, 3'd5, 10'd5, 1, 1);
    idle(2, 1);

    // T6: error counting
    do_reset();
    cyc(1, 20'd1, 3'd0, 10'd1, 0, 1);
    cyc(1, 20'd2, 3'd2, 10'd2, 0, 1);
    cyc(1, 20'd3, 3'd7, 10'd3, 0, 1);
    cyc(1, 20'd4, 3'd0, 10'd4, 0, 1);
    idle(3, 1);

    // Fin arriving with an empty FIFO
    do_reset();
    cyc(0, 20'd0, 3'd0, 10'd0, 1, 0);
    idle(3, 0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 1100; i++) cyc(1, 20'(i), 3'(i), 10'(i), 0, 1);

    // Randomized episodes
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      pdv    = $urandom_range(90, 20);
      prdy   = $urandom_range(90, 10);
      fin_at = $urandom_range(350, 150);
      for (int i = 0; i < 400; i++) begin
        rd = 20'($urandom);
        re = ($urandom_range(99) < 60) ? 3'd0 : 3'($urandom);
        rp = 10'($urandom);
        cyc($urandom_range(99) < pdv, rd, re, rp, i == fin_at,
            $urandom_range(99) < prdy);
      end
      idle(20, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
